// File: rtl/lieat_regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register long-latency scoreboard (pending bits, occupancy count, empty flag).
module lieat_regfile_mp #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int IDXW   = 5,
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NRD*IDXW-1:0]  rd_idx,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*IDXW-1:0]  wr_idx,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NWR-1:0]       wr_long,
  input  logic                 iss_en,
  input  logic [IDXW-1:0]      iss_idx,
  output logic                 iss_conflict,
  input  logic                 flush,
  output logic [IDXW:0]        sb_count,
  output logic                 sb_empty
);

  logic [XLEN-1:0] regs_q   [NREG];
  logic [XLEN-1:0] wr_val   [NREG];
  logic [NREG-1:0] wr_hit;
  logic [NREG-1:0] long_clr;
  logic [NREG-1:0] iss_hit;
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_nxt;
  logic [IDXW:0]   cnt_nxt;
  logic [IDXW:0]   sb_count_q;
  logic            sb_empty_q;

  // Per-register write merge. Ports are scanned upward so the highest-numbered
  // enabled port wins; register 0 and out-of-range indices never match.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_hit[r]   = 1'b0;
      long_clr[r] = 1'b0;
      wr_val[r]   = '0;
      if (r != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wr_en[k] && (wr_idx[k*IDXW +: IDXW] == IDXW'(r))) begin
            wr_hit[r] = 1'b1;
            wr_val[r] = wr_data[k*XLEN +: XLEN];
            if (wr_long[k]) begin
              long_clr[r] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      iss_hit[r] = iss_en && (r != 0) && (iss_idx == IDXW'(r));
    end
  end

  // Pending next state: flush beats issue, issue beats a same-cycle clear.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      if (r == 0) begin
        pend_nxt[r] = 1'b0;
      end else if (flush) begin
        pend_nxt[r] = 1'b0;
      end else if (iss_hit[r]) begin
        pend_nxt[r] = 1'b1;
      end else if (long_clr[r]) begin
        pend_nxt[r] = 1'b0;
      end else begin
        pend_nxt[r] = pend_q[r];
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_nxt = cnt_nxt + (IDXW+1)'(pend_nxt[r]);
    end
  end

  // Read ports: register 0 and out-of-range indices read zero and are never busy.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_idx[p*IDXW +: IDXW] == IDXW'(r)) begin
          if ((BYPASS != 0) && wr_hit[r]) begin
            rd_data[p*XLEN +: XLEN] = wr_val[r];
          end else begin
            rd_data[p*XLEN +: XLEN] = regs_q[r];
          end
          rd_busy[p] = pend_q[r] & ~((BYPASS != 0) & long_clr[r]);
        end
      end
    end
  end

  always_comb begin
    iss_conflict = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (iss_idx == IDXW'(r)) begin
        iss_conflict = iss_en & pend_q[r] & ~long_clr[r] & ~flush;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_hit[r]) begin
          regs_q[r] <= wr_val[r];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q     <= '0;
      sb_count_q <= '0;
      sb_empty_q <= 1'b1;
    end else begin
      pend_q     <= pend_nxt;
      sb_count_q <= cnt_nxt;
      sb_empty_q <= (cnt_nxt == '0);
    end
  end

  assign sb_count = sb_count_q;
  assign sb_empty = sb_empty_q;

endmodule

// File: tb/tb_lieat_regfile_mp.sv
// Bench for lieat_regfile_mp: bypass and non-bypass instances share stimulus and
// are compared against an array-based reference model.
module tb_lieat_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int IDXW = 5;
  localparam int NRD  = 3;
  localparam int NWR  = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NRD*IDXW-1:0] rd_idx;
  logic [NWR-1:0]      wr_en;
  logic [NWR*IDXW-1:0] wr_idx;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NWR-1:0]      wr_long;
  logic                iss_en;
  logic [IDXW-1:0]     iss_idx;
  logic                flush;

  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic                conf_b, conf_n;
  logic [IDXW:0]       cnt_b, cnt_n;
  logic                empty_b, empty_n;

  int n_checks = 0;
  int n_pass   = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];

  lieat_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .IDXW(IDXW), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
    .clock(clock), .reset(reset), .rd_idx(rd_idx), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_long(wr_long),
    .iss_en(iss_en), .iss_idx(iss_idx), .iss_conflict(conf_b), .flush(flush),
    .sb_count(cnt_b), .sb_empty(empty_b)
  );

  lieat_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .IDXW(IDXW), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
    .clock(clock), .reset(reset), .rd_idx(rd_idx), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_long(wr_long),
    .iss_en(iss_en), .iss_idx(iss_idx), .iss_conflict(conf_n), .flush(flush),
    .sb_count(cnt_n), .sb_empty(empty_n)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model
  function automatic int wr_i(int k);
    return int'(wr_idx[k*IDXW +: IDXW]);
  endfunction

  function automatic logic [XLEN-1:0] m_read(int idx, bit byp);
    if (idx == 0) return '0;
    if (byp)
      for (int k = NWR-1; k >= 0; k--)
        if (wr_en[k] && wr_i(k) == idx) return wr_data[k*XLEN +: XLEN];
    return m_regs[idx];
  endfunction

  function automatic bit m_clears(int idx);
    if (idx == 0) return 1'b0;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && wr_long[k] && wr_i(k) == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_pend[r]);
    return c;
  endfunction

  function automatic void m_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endfunction

  function automatic void m_update();
    bit np [NREG];
    for (int r = 0; r < NREG; r++) np[r] = flush ? 1'b0 : (m_clears(r) ? 1'b0 : m_pend[r]);
    if (!flush && iss_en && iss_idx != 0) np[int'(iss_idx)] = 1'b1;
    for (int k = 0; k < NWR; k++)
      if (wr_en[k] && wr_i(k) != 0) m_regs[wr_i(k)] = wr_data[k*XLEN +: XLEN];
    m_pend = np;
  endfunction

  task automatic check_all(input string tag);
    int  idx;
    bit  econf;
    for (int p = 0; p < NRD; p++) begin
      idx = int'(rd_idx[p*IDXW +: IDXW]);
      chk($sformatf("%s rd_data_b[%0d]", tag, p), 64'(rd_data_b[p*XLEN +: XLEN]), 64'(m_read(idx, 1'b1)));
      chk($sformatf("%s rd_data_n[%0d]", tag, p), 64'(rd_data_n[p*XLEN +: XLEN]), 64'(m_read(idx, 1'b0)));
      chk($sformatf("%s rd_busy_b[%0d]", tag, p), 64'(rd_busy_b[p]), 64'(m_pend[idx] && !m_clears(idx)));
      chk($sformatf("%s rd_busy_n[%0d]", tag, p), 64'(rd_busy_n[p]), 64'(m_pend[idx]));
    end
    econf = iss_en && !flush && m_pend[int'(iss_idx)] && !m_clears(int'(iss_idx));
    chk({tag, " conflict_b"}, 64'(conf_b), 64'(econf));
    chk({tag, " conflict_n"}, 64'(conf_n), 64'(econf));
    chk({tag, " sb_count_b"}, 64'(cnt_b), 64'(m_count()));
    chk({tag, " sb_count_n"}, 64'(cnt_n), 64'(m_count()));
    chk({tag, " sb_empty_b"}, 64'(empty_b), 64'(m_count() == 0));
    chk({tag, " sb_empty_n"}, 64'(empty_n), 64'(m_count() == 0));
  endtask

  // Driver tasks
  task automatic idle();
    wr_en = '0; wr_long = '0; iss_en = 1'b0; flush = 1'b0;
  endtask

  task automatic set_wr(input int k, input int idx, input logic [XLEN-1:0] d, input bit lng);
    wr_en[k] = 1'b1;
    wr_long[k] = lng;
    wr_idx[k*IDXW +: IDXW] = IDXW'(idx);
    wr_data[k*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int p, input int idx);
    rd_idx[p*IDXW +: IDXW] = IDXW'(idx);
  endtask

  task automatic issue(input int idx);
    iss_en = 1'b1;
    iss_idx = IDXW'(idx);
  endtask

  task automatic tick();
    @(posedge clock);
    if (!reset) m_update();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    rd_idx = '0; wr_idx = '0; wr_data = '0; iss_idx = '0;
    m_reset();
    @(negedge clock);
    for (int p = 0; p < NRD; p++) set_rd(p, 5);
    #1 check_all("reset");
    chk("reset empty", 64'(empty_b), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // Write x5, then async reset mid-cycle
    set_wr(0, 5, 32'h1234, 1'b0);
    tick(); idle();
    #1 check_all("x5 written");
    chk("x5 value", 64'(rd_data_b[XLEN-1:0]), 64'h1234);
    reset = 1'b1;
    #1 m_reset();
    check_all("mid reset");
    chk("x5 after reset", 64'(rd_data_b[XLEN-1:0]), 64'h0);
    tick();
    reset = 1'b0;

    // Two ports write x7: port 1 wins
    set_wr(0, 7, 32'hAAAA, 1'b0);
    set_wr(1, 7, 32'h5555, 1'b0);
    set_rd(0, 7);
    #1 check_all("dual write");
    chk("bypass same cycle", 64'(rd_data_b[XLEN-1:0]), 64'h5555);
    chk("no bypass old", 64'(rd_data_n[XLEN-1:0]), 64'h0);
    tick(); idle();
    #1 check_all("dual write next");
    chk("stored x7 b", 64'(rd_data_b[XLEN-1:0]), 64'h5555);
    chk("stored x7 n", 64'(rd_data_n[XLEN-1:0]), 64'h5555);

    // x0 is immutable and never pending
    set_wr(0, 0, 32'hFFFF, 1'b0);
    issue(0);
    set_rd(0, 0);
    #1 check_all("x0 write");
    chk("x0 read", 64'(rd_data_b[XLEN-1:0]), 64'h0);
    chk("x0 conflict", 64'(conf_b), 64'h0);
    tick(); idle();
    #1 check_all("x0 after");
    chk("x0 count", 64'(cnt_b), 64'h0);

    // Issue x3, x9; then long write-back clears x3
    issue(3);
    tick(); idle();
    #1 chk("count 1", 64'(cnt_b), 64'd1);
    issue(9);
    tick(); idle();
    set_rd(0, 3);
    #1 check_all("x3 x9 pending");
    chk("count 2", 64'(cnt_b), 64'd2);
    chk("x3 busy", 64'(rd_busy_b[0]), 64'd1);
    set_wr(0, 3, 32'h33, 1'b1);
    #1 check_all("x3 clear");
    chk("x3 busy bypassed", 64'(rd_busy_b[0]), 64'd0);
    tick(); idle();
    #1 check_all("x3 cleared");
    chk("count after clear", 64'(cnt_b), 64'd1);

    // Issue beats same-cycle clear, then re-issue conflicts
    issue(4);
    tick(); idle();
    issue(4);
    set_wr(1, 4, 32'h44, 1'b1);
    set_rd(1, 4);
    #1 check_all("issue vs clear");
    chk("no conflict on clear", 64'(conf_b), 64'd0);
    tick(); idle();
    #1 check_all("x4 still pending");
    chk("x4 busy", 64'(rd_busy_b[1]), 64'd1);
    issue(4);
    #1 check_all("x4 reissue");
    chk("x4 conflict", 64'(conf_b), 64'd1);
    tick(); idle();

    // Flush discards same-cycle issue
    issue(1); tick(); idle();
    issue(2); tick(); idle();
    issue(3); tick(); idle();
    flush = 1'b1;
    issue(6);
    #1 check_all("flush");
    tick(); idle();
    set_rd(2, 6);
    #1 check_all("after flush");
    chk("flush count", 64'(cnt_b), 64'd0);
    chk("flush empty", 64'(empty_b), 64'd1);
    chk("x6 not busy", 64'(rd_busy_b[2]), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      for (int k = 0; k < NWR; k++)
        if ($urandom_range(0, 1) == 1)
          set_wr(k, int'($urandom_range(0, NREG-1)), $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) issue(int'($urandom_range(0, NREG-1)));
      flush = ($urandom_range(0, 31) == 0);
      for (int p = 0; p < NRD; p++) begin
        if ($urandom_range(0, 2) == 0) set_rd(p, wr_i(int'($urandom_range(0, NWR-1))));
        else if ($urandom_range(0, 3) == 0) set_rd(p, int'(iss_idx));
        else set_rd(p, int'($urandom_range(0, NREG-1)));
      end
      #1 check_all($sformatf("rand%0d", i));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
